arp_resolver: RTL and testbench
===============================

# arp_resolver

Requester-side companion to the ARP cache. Accepts IP-to-MAC resolution requests from the IP transmit path, selects the next-hop IP by subnet and gateway rules, and queries the cache. On a miss it emits ARP request descriptors to the ARP frame transmitter and re-polls the cache until a hit or retry exhaustion. It sits between the IP TX path, the ARP cache query port and the ARP TX descriptor port.

## Interface
- RETRY_COUNT, 4: maximum ARP requests sent per resolution; 0 means error on the first miss.
- RETRY_INTERVAL, 250000000: cycles between successive ARP requests for one resolution.
- POLL_INTERVAL, 1000: cycles between cache re-queries while waiting.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- arp_request_valid / arp_request_ready  in / out  1  resolution request handshake.
- arp_request_ip  in  32  destination IP.
- arp_response_valid / arp_response_ready  out / in  1  result handshake.
- arp_response_error  out  1  1 = unresolved.
- arp_response_mac  out  48  resolved MAC.
- cache_query_request_valid / cache_query_request_ready  out / in  1  cache query handshake.
- cache_query_request_ip  out  32  next-hop IP.
- cache_query_response_valid / cache_query_response_ready  in / out  1  cache response handshake.
- cache_query_response_error  in  1  cache miss.
- cache_query_response_mac  in  48  cached MAC.
- arp_tx_valid / arp_tx_ready  out / in  1  ARP request descriptor handshake.
- arp_tx_ip  out  32  target IP for the ARP request.
- local_ip, gateway_ip, subnet_mask  in  32 each  configuration; sampled only at request acceptance.

## Operation
- States: IDLE, QUERY, WAIT_RESP, SEND_ARP, WAIT_POLL, RESPOND. One request in flight.
- **IDLE**
  - arp_request_ready = 1.
  - cache_query_response_ready = 1; any cache response arriving here is dropped. This flushes stale responses after reset.
- **On accept:** latch ip; clear retry_cnt; clear retry_timer; then classify:
  - **Broadcast:** ip == FFFFFFFF, or (ip & mask) == (local_ip & mask) and (ip | mask) == FFFFFFFF. Go to RESPOND with mac FFFFFFFFFFFF, error 0.
  - **On-subnet** (ip & mask) == (local_ip & mask): target = ip.
  - **Off-subnet:** target = gateway_ip. If gateway_ip == 0, go to RESPOND with error 1, mac 0.
  - Otherwise go to QUERY.
- **QUERY:** cache_query_request_valid = 1, cache_query_request_ip = target. On handshake, go to WAIT_RESP.
- **WAIT_RESP:** cache_query_response_ready = 1. On a response:
  - error 0: go to RESPOND with the cached mac, error 0.
  - error 1 and retry_timer != 0: go to WAIT_POLL with poll_timer = POLL_INTERVAL-1.
  - error 1, retry_timer == 0, retry_cnt == RETRY_COUNT: go to RESPOND with error 1, mac 0.
  - error 1, retry_timer == 0, otherwise: go to SEND_ARP.
- **SEND_ARP:** arp_tx_valid = 1, arp_tx_ip = target. On handshake:
  - retry_cnt += 1
  - retry_timer = RETRY_INTERVAL-1
  - poll_timer = POLL_INTERVAL-1
  - go to WAIT_POLL.
- **WAIT_POLL:** when poll_timer == 0, go to QUERY; otherwise decrement it.
- **Retry timer:** decrements, saturating at 0, every cycle in QUERY, WAIT_RESP, WAIT_POLL.
- **RESPOND:** arp_response_valid = 1 until arp_response_ready, then go to IDLE.
- **Widths:**
  - retry_cnt is $clog2(RETRY_COUNT+1) bits.
  - Timers are $clog2 of their interval, minimum 1 bit.
  - No wrap: retry_cnt never exceeds RETRY_COUNT.

## Timing
- **Reset values:** all *_valid outputs 0, all ready outputs 0, data outputs 0, state IDLE. arp_request_ready rises on the first clk edge after rst_n deasserts.
- **Registered outputs:** all outputs are registered. No combinational path from any input to any output.
- **Request accept:** request accepted in cycle T, then:
  - cache_query_request_valid asserts at T+1.
  - For broadcast or no-gateway error, arp_response_valid asserts at T+1.
- **Cache hit:** cache response handshake in cycle C gives arp_response_valid at C+1.
- **ARP request:** first miss response in cycle C gives arp_tx_valid at C+1.
- **Re-query after ARP:** arp_tx handshake in cycle A gives cache_query_request_valid at A+POLL_INTERVAL+1.
- **Hold rules:**
  - Valid outputs and their data hold stable while valid && !ready.
  - Valid is never withdrawn before its handshake.
- **Mid-operation reset:** asynchronous return to IDLE. An outstanding cache response is absorbed in IDLE.

## Structure
- **Package arp_pkg:**
  - state enum.
  - ARP_BCAST_MAC = 48'hFFFFFFFFFFFF.
  - IP_BCAST = 32'hFFFFFFFF.
- **Sub-module:** one natural combinational sub-module, arp_target_select (broadcast / on-subnet / gateway classification). The FSM and timers live in arp_resolver.

## Test plan
- **Cache hit:**
  - Setup: local 192.168.1.128/24; cache holds 192.168.1.10 → 02:00:00:00:00:0A.
  - Stimulus: request 192.168.1.10.
  - Response: query ip C0A8010A, response mac 02000000000A, error 0, no arp_tx.
- **Broadcast:**
  - Stimulus: request 192.168.1.255, then FFFFFFFF.
  - Response: each returns FFFFFFFFFFFF, error 0, at T+1. No cache query.
- **Off-subnet:**
  - Setup: gateway 192.168.1.1.
  - Stimulus: request 8.8.8.8.
  - Response: query ip C0A80101. With gateway_ip 0, error 1 at T+1.
- **Miss then learn:**
  - Setup: POLL_INTERVAL 8, RETRY_INTERVAL 100.
  - Stimulus: cache misses twice, then hits.
  - Response: exactly one arp_tx (ip C0A8010A), then a hit returned with error 0.
- **Exhaustion:**
  - Setup: RETRY_COUNT 2, cache always misses.
  - Response: exactly 2 arp_tx, spaced ≥ RETRY_INTERVAL, then error 1, mac 0.
- **Backpressure and reset:**
  - Stimulus: hold arp_response_ready 0 for 5 cycles; then pulse rst_n low during WAIT_RESP.
  - Response: outputs stable while stalled. After reset, all outputs 0, and a late cache response is consumed in IDLE without producing arp_response_valid.

Source files
------------

// File: rtl/arp_pkg.sv
// arp_pkg: shared state encoding and constants for the ARP resolver.
package arp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUERY,
        ST_WAIT_RESP,
        ST_SEND_ARP,
        ST_WAIT_POLL,
        ST_RESPOND
    } state_t;

    localparam logic [47:0] ARP_BCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] IP_BCAST      = 32'hFFFF_FFFF;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arp_resolver_target_select.sv
// arp_target_select: classifies a destination IP as broadcast, on-subnet or
// gateway-routed and yields the next-hop IP to look up.
module arp_target_select
    import arp_pkg::*;
(
    input  logic [31:0] ip,
    input  logic [31:0] local_ip,
    input  logic [31:0] gateway_ip,
    input  logic [31:0] subnet_mask,
    output logic        is_bcast,
    output logic        no_route,
    output logic [31:0] target
);

    logic on_subnet;

    assign on_subnet = (ip & subnet_mask) == (local_ip & subnet_mask);
    assign is_bcast  = (ip == IP_BCAST) || (on_subnet && ((ip | subnet_mask) == IP_BCAST));
    assign target    = on_subnet ? ip : gateway_ip;
    assign no_route  = !on_subnet && (gateway_ip == '0);

endmodule

// File: rtl/arp_resolver.sv
// arp_resolver: resolves a next-hop MAC through the ARP cache, sending ARP
// request descriptors and re-polling the cache while the entry is missing.
//   state     | meaning
//   IDLE      | accepting a request; stray cache responses are absorbed
//   QUERY     | cache query presented
//   WAIT_RESP | waiting for the cache answer
//   SEND_ARP  | ARP request descriptor presented
//   WAIT_POLL | counting down to the next cache query
//   RESPOND   | result presented to the IP TX path
module arp_resolver
    import arp_pkg::*;
#(
    parameter int RETRY_COUNT    = 4,
    parameter int RETRY_INTERVAL = 250000000,
    parameter int POLL_INTERVAL  = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arp_request_valid,
    output logic        arp_request_ready,
    input  logic [31:0] arp_request_ip,
    output logic        arp_response_valid,
    input  logic        arp_response_ready,
    output logic        arp_response_error,
    output logic [47:0] arp_response_mac,
    output logic        cache_query_request_valid,
    input  logic        cache_query_request_ready,
    output logic [31:0] cache_query_request_ip,
    input  logic        cache_query_response_valid,
    output logic        cache_query_response_ready,
    input  logic        cache_query_response_error,
    input  logic [47:0] cache_query_response_mac,
    output logic        arp_tx_valid,
    input  logic        arp_tx_ready,
    output logic [31:0] arp_tx_ip,
    input  logic [31:0] local_ip,
    input  logic [31:0] gateway_ip,
    input  logic [31:0] subnet_mask
);

    localparam int RC_W = clog2_min1(RETRY_COUNT + 1);
    localparam int RT_W = clog2_min1(RETRY_INTERVAL);
    localparam int PT_W = clog2_min1(POLL_INTERVAL);
    localparam logic [RC_W-1:0] RETRY_MAX    = RC_W'(RETRY_COUNT);
    localparam logic [RT_W-1:0] RETRY_RELOAD = RT_W'(RETRY_INTERVAL - 1);
    localparam logic [PT_W-1:0] POLL_RELOAD  = PT_W'(POLL_INTERVAL - 1);

    state_t          state, state_next;
    logic [31:0]     target, target_next;
    logic [RC_W-1:0] retry_cnt, retry_cnt_next;
    logic [RT_W-1:0] retry_timer, retry_timer_next;
    logic [PT_W-1:0] poll_timer, poll_timer_next;
    logic [47:0]     mac_next;
    logic            error_next;
    logic            req_ready_next, resp_valid_next, cq_req_valid_next;
    logic            cq_resp_ready_next, tx_valid_next;

    logic            sel_bcast, sel_no_route;
    logic [31:0]     sel_target;

    arp_target_select u_target_select (
        .ip          (arp_request_ip),
        .local_ip    (local_ip),
        .gateway_ip  (gateway_ip),
        .subnet_mask (subnet_mask),
        .is_bcast    (sel_bcast),
        .no_route    (sel_no_route),
        .target      (sel_target)
    );

    // Query and ARP descriptor both carry the latched next-hop address.
    assign cache_query_request_ip = target;
    assign arp_tx_ip              = target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                      <= ST_IDLE;
            target                     <= '0;
            retry_cnt                  <= '0;
            retry_timer                <= '0;
            poll_timer                 <= '0;
            arp_response_mac           <= '0;
            arp_response_error         <= 1'b0;
            arp_request_ready          <= 1'b0;
            arp_response_valid         <= 1'b0;
            cache_query_request_valid  <= 1'b0;
            cache_query_response_ready <= 1'b0;
            arp_tx_valid               <= 1'b0;
        end else begin
            state                      <= state_next;
            target                     <= target_next;
            retry_cnt                  <= retry_cnt_next;
            retry_timer                <= retry_timer_next;
            poll_timer                 <= poll_timer_next;
            arp_response_mac           <= mac_next;
            arp_response_error         <= error_next;
            arp_request_ready          <= req_ready_next;
            arp_response_valid         <= resp_valid_next;
            cache_query_request_valid  <= cq_req_valid_next;
            cache_query_response_ready <= cq_resp_ready_next;
            arp_tx_valid               <= tx_valid_next;
        end
    end

    always_comb begin
        state_next       = state;
        target_next      = target;
        retry_cnt_next   = retry_cnt;
        retry_timer_next = retry_timer;
        poll_timer_next  = poll_timer;
        mac_next         = arp_response_mac;
        error_next       = arp_response_error;

        if ((state inside {ST_QUERY, ST_WAIT_RESP, ST_WAIT_POLL}) && retry_timer != '0)
            retry_timer_next = retry_timer - RT_W'(1);

        case (state)
            ST_IDLE: begin
                if (arp_request_valid && arp_request_ready) begin
                    retry_cnt_next   = '0;
                    retry_timer_next = '0;
                    target_next      = sel_target;
                    if (sel_bcast) begin
                        state_next = ST_RESPOND;
                        mac_next   = ARP_BCAST_MAC;
                        error_next = 1'b0;
                    end else if (sel_no_route) begin
                        state_next = ST_RESPOND;
                        mac_next   = '0;
                        error_next = 1'b1;
                    end else begin
                        state_next = ST_QUERY;
                    end
                end
            end
            ST_QUERY: begin
                if (cache_query_request_valid && cache_query_request_ready)
                    state_next = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                if (cache_query_response_valid && cache_query_response_ready) begin
                    if (!cache_query_response_error) begin
                        state_next = ST_RESPOND;
                        mac_next   = cache_query_response_mac;
                        error_next = 1'b0;
                    end else if (retry_timer != '0) begin
                        state_next      = ST_WAIT_POLL;
                        poll_timer_next = POLL_RELOAD;
                    end else if (retry_cnt == RETRY_MAX) begin
                        state_next = ST_RESPOND;
                        mac_next   = '0;
                        error_next = 1'b1;
                    end else begin
                        state_next = ST_SEND_ARP;
                    end
                end
            end
            ST_SEND_ARP: begin
                if (arp_tx_valid && arp_tx_ready) begin
                    retry_cnt_next   = retry_cnt + RC_W'(1);
                    retry_timer_next = RETRY_RELOAD;
                    poll_timer_next  = POLL_RELOAD;
                    state_next       = ST_WAIT_POLL;
                end
            end
            ST_WAIT_POLL: begin
                if (poll_timer == '0) state_next = ST_QUERY;
                else                  poll_timer_next = poll_timer - PT_W'(1);
            end
            ST_RESPOND: begin
                if (arp_response_valid && arp_response_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered from the upcoming state.
    always_comb begin
        req_ready_next     = (state_next == ST_IDLE);
        resp_valid_next    = (state_next == ST_RESPOND);
        cq_req_valid_next  = (state_next == ST_QUERY);
        cq_resp_ready_next = (state_next == ST_IDLE) || (state_next == ST_WAIT_RESP);
        tx_valid_next      = (state_next == ST_SEND_ARP);
    end

endmodule

// File: tb/tb_arp_resolver.sv
// tb_arp_resolver: table-driven resolution vectors against a small cache model,
// plus stall and mid-operation reset sequences.
module tb_arp_resolver;

    localparam int RC = 2;
    localparam int RI = 100;
    localparam int PI = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arp_request_valid, arp_request_ready;
    logic [31:0] arp_request_ip;
    logic        arp_response_valid, arp_response_ready, arp_response_error;
    logic [47:0] arp_response_mac;
    logic        cache_query_request_valid, cache_query_request_ready;
    logic [31:0] cache_query_request_ip;
    logic        cache_query_response_valid, cache_query_response_ready;
    logic        cache_query_response_error;
    logic [47:0] cache_query_response_mac;
    logic        arp_tx_valid, arp_tx_ready;
    logic [31:0] arp_tx_ip;
    logic [31:0] local_ip, gateway_ip, subnet_mask;

    arp_resolver #(.RETRY_COUNT(RC), .RETRY_INTERVAL(RI), .POLL_INTERVAL(PI)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .arp_request_valid          (arp_request_valid),
        .arp_request_ready          (arp_request_ready),
        .arp_request_ip             (arp_request_ip),
        .arp_response_valid         (arp_response_valid),
        .arp_response_ready         (arp_response_ready),
        .arp_response_error         (arp_response_error),
        .arp_response_mac           (arp_response_mac),
        .cache_query_request_valid  (cache_query_request_valid),
        .cache_query_request_ready  (cache_query_request_ready),
        .cache_query_request_ip     (cache_query_request_ip),
        .cache_query_response_valid (cache_query_response_valid),
        .cache_query_response_ready (cache_query_response_ready),
        .cache_query_response_error (cache_query_response_error),
        .cache_query_response_mac   (cache_query_response_mac),
        .arp_tx_valid               (arp_tx_valid),
        .arp_tx_ready               (arp_tx_ready),
        .arp_tx_ip                  (arp_tx_ip),
        .local_ip                   (local_ip),
        .gateway_ip                 (gateway_ip),
        .subnet_mask                (subnet_mask)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [47:0] mac;
    } resp_t;

    typedef struct {
        logic [31:0] ip, lip, gw, mask;
        int          misses;
        logic        err;
        logic [47:0] mac;
        logic [31:0] target;
        bit          fast;
        int          n_arp;
        int          n_query;
    } vec_t;

    resp_t       exp_q[$];
    vec_t        vecs[11];
    int          checks = 0, errors = 0;
    int          n_query = 0, n_arp = 0, n_resp = 0;
    int          arps_this_req = 0, arp_edge = 0;
    bit          requery_pending = 0;
    logic [31:0] exp_target = '0;
    bit          cache_auto = 1;
    int          cache_resp_cnt = 0, miss_base = 0, miss_budget = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [47:0] cache_mac(input logic [31:0] ip);
        return {40'h02_0000_0000, ip[7:0]};
    endfunction

    task automatic check_zero(input string tag);
        check({tag, " ctl"}, 64'({arp_request_ready, arp_response_valid, arp_response_error,
              cache_query_request_valid, cache_query_response_ready, arp_tx_valid}), 64'd0);
        check({tag, " mac"}, 64'(arp_response_mac), 64'd0);
        check({tag, " ips"}, {cache_query_request_ip, arp_tx_ip}, 64'd0);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        @(negedge clk);
        check("ready before first edge", 64'(arp_request_ready), 64'd0);
        @(negedge clk);
        check("ready after first edge", 64'(arp_request_ready), 64'd1);
    endtask

    task automatic do_request(input logic [31:0] ip, input bit push, input logic err,
                              input logic [47:0] mac);
        int w = 0;
        arp_request_ip    = ip;
        arp_request_valid = 1'b1;
        @(negedge clk);
        while (!arp_request_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("request accepted", 64'(arp_request_ready), 64'd1);
        if (push) exp_q.push_back('{err, mac});
        @(posedge clk);
        #1;
        arp_request_valid = 1'b0;
    endtask

    task automatic wait_resp(input int target_cnt, input int limit);
        int w = 0;
        while (n_resp < target_cnt && w < limit) begin
            @(negedge clk);
            w++;
        end
        check("response arrived", 64'(n_resp >= target_cnt), 64'd1);
    endtask

    // Cache model: answers each query two cycles after its handshake.
    initial begin
        logic [31:0] qip;
        bit          miss;
        int          idx, w;
        cache_query_response_valid = 1'b0;
        cache_query_response_error = 1'b0;
        cache_query_response_mac   = '0;
        forever begin
            @(negedge clk);
            if (cache_auto && rst_n && cache_query_request_valid && cache_query_request_ready) begin
                qip = cache_query_request_ip;
                @(posedge clk); #1;
                @(posedge clk); #1;
                idx  = cache_resp_cnt - miss_base;
                miss = idx < miss_budget;
                cache_query_response_valid = 1'b1;
                cache_query_response_error = miss;
                cache_query_response_mac   = miss ? 48'h0 : cache_mac(qip);
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!cache_query_response_ready && w < 50);
                check("cache response taken", 64'(cache_query_response_ready), 64'd1);
                @(posedge clk); #1;
                cache_query_response_valid = 1'b0;
                cache_resp_cnt++;
                @(negedge clk);
                if (!miss)
                    check("hit gives response next cycle", 64'(arp_response_valid), 64'd1);
                else if (idx == 0)
                    check("first miss gives arp_tx next cycle", 64'(arp_tx_valid), 64'd1);
            end
        end
    end

    // Monitor: query/arp/response handshakes against the scoreboard.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (arp_request_valid && arp_request_ready) arps_this_req = 0;
                if (requery_pending && cache_query_request_valid) begin
                    check("requery after arp", 64'(cyc), 64'(arp_edge + PI));
                    requery_pending = 0;
                end
                if (cache_query_request_valid && cache_query_request_ready) begin
                    n_query++;
                    check("query ip", 64'(cache_query_request_ip), 64'(exp_target));
                end
                if (arp_tx_valid && arp_tx_ready) begin
                    n_arp++;
                    arps_this_req++;
                    check("arp ip", 64'(arp_tx_ip), 64'(exp_target));
                    if (arps_this_req > 1) begin
                        checks++;
                        if (cyc + 1 - arp_edge < RI) begin
                            errors++;
                            $display("FAIL arp spacing: got %0d cycles, need >= %0d",
                                     cyc + 1 - arp_edge, RI);
                        end
                    end
                    arp_edge = cyc + 1;
                    requery_pending = 1;
                end
                if (arp_response_valid && arp_response_ready) begin
                    n_resp++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected response: got mac %h err %b, none expected",
                                 arp_response_mac, arp_response_error);
                    end else begin
                        r = exp_q.pop_front();
                        check("response error", 64'(arp_response_error), 64'(r.err));
                        check("response mac", 64'(arp_response_mac), 64'(r.mac));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, qb, ab, w;
        bit saw_resp;
        arp_request_valid          = 1'b0;
        arp_request_ip             = '0;
        arp_response_ready         = 1'b1;
        cache_query_request_ready  = 1'b1;
        arp_tx_ready               = 1'b1;
        local_ip                   = 32'hC0A80180;
        gateway_ip                 = 32'hC0A80101;
        subnet_mask                = 32'hFFFFFF00;

        //          ip            local         gw            mask          miss err mac               target        fast arp q
        vecs[0]  = '{32'hC0A8010A, 32'hC0A80180, 32'hC0A80101, 32'hFFFFFF00, 0,   1'b0, 48'h02000000000A, 32'hC0A8010A, 1'b0, 0, 1};
        vecs[1]  = '{32'hC0A801FF, 32'hC0A80180, 32'hC0A80101, 32'hFFFFFF00, 0,   1'b0, 48'hFFFFFFFFFFFF, 32'h0,        1'b1, 0, 0};
        vecs[2]  = '{32'hFFFFFFFF, 32'hC0A80180, 32'hC0A80101, 32'hFFFFFF00, 0,   1'b0, 48'hFFFFFFFFFFFF, 32'h0,        1'b1, 0, 0};
        vecs[3]  = '{32'h08080808, 32'hC0A80180, 32'hC0A80101, 32'hFFFFFF00, 0,   1'b0, 48'h020000000001, 32'hC0A80101, 1'b0, 0, 1};
        vecs[4]  = '{32'h08080808, 32'hC0A80180, 32'h00000000, 32'hFFFFFF00, 0,   1'b1, 48'h000000000000, 32'h0,        1'b1, 0, 0};
        vecs[5]  = '{32'hC0A80137, 32'hC0A80180, 32'hC0A80101, 32'hFFFFFF00, 0,   1'b0, 48'h020000000037, 32'hC0A80137, 1'b0, 0, 1};
        vecs[6]  = '{32'h0AFFFFFF, 32'h0A000005, 32'h0A000001, 32'hFF000000, 0,   1'b0, 48'hFFFFFFFFFFFF, 32'h0,        1'b1, 0, 0};
        vecs[7]  = '{32'h0A123456, 32'h0A000005, 32'h0A000001, 32'hFF000000, 0,   1'b0, 48'h020000000056, 32'h0A123456, 1'b0, 0, 1};
        vecs[8]  = '{32'h0B000001, 32'h0A000005, 32'h0A000001, 32'hFF000000, 0,   1'b0, 48'h020000000001, 32'h0A000001, 1'b0, 0, 1};
        vecs[9]  = '{32'hC0A8010A, 32'hC0A80180, 32'hC0A80101, 32'hFFFFFF00, 2,   1'b0, 48'h02000000000A, 32'hC0A8010A, 1'b0, 1, 3};
        vecs[10] = '{32'hC0A80114, 32'hC0A80180, 32'hC0A80101, 32'hFFFFFF00, 1000, 1'b1, 48'h000000000000, 32'hC0A80114, 1'b0, 2, -1};

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        release_reset();
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            local_ip    = vecs[i].lip;
            gateway_ip  = vecs[i].gw;
            subnet_mask = vecs[i].mask;
            exp_target  = vecs[i].target;
            miss_base   = cache_resp_cnt;
            miss_budget = vecs[i].misses;
            base = n_resp;
            qb   = n_query;
            ab   = n_arp;
            do_request(vecs[i].ip, 1'b1, vecs[i].err, vecs[i].mac);
            @(negedge clk);
            if (vecs[i].fast) begin
                check($sformatf("v%0d response at T+1", i), 64'(arp_response_valid), 64'd1);
                check($sformatf("v%0d no query", i), 64'(cache_query_request_valid), 64'd0);
            end else begin
                check($sformatf("v%0d query at T+1", i), 64'(cache_query_request_valid), 64'd1);
            end
            wait_resp(base + 1, 3000);
            check($sformatf("v%0d arp count", i), 64'(n_arp - ab), 64'(vecs[i].n_arp));
            if (vecs[i].n_query >= 0)
                check($sformatf("v%0d query count", i), 64'(n_query - qb), 64'(vecs[i].n_query));
            @(posedge clk); #1;
        end

        // Stall both the cache query and the result; both must hold.
        local_ip    = 32'hC0A80180;
        gateway_ip  = 32'hC0A80101;
        subnet_mask = 32'hFFFFFF00;
        exp_target  = 32'hC0A8010A;
        miss_base   = cache_resp_cnt;
        miss_budget = 0;
        base = n_resp;
        cache_query_request_ready = 1'b0;
        arp_response_ready        = 1'b0;
        do_request(32'hC0A8010A, 1'b1, 1'b0, 48'h02000000000A);
        repeat (4) begin
            @(negedge clk);
            check("query hold valid", 64'(cache_query_request_valid), 64'd1);
            check("query hold ip", 64'(cache_query_request_ip), 64'hC0A8010A);
        end
        @(posedge clk); #1;
        cache_query_request_ready = 1'b1;
        w = 0;
        while (!arp_response_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("stalled response seen", 64'(arp_response_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            check("stall valid", 64'(arp_response_valid), 64'd1);
            check("stall mac", 64'(arp_response_mac), 64'h02000000000A);
            check("stall error", 64'(arp_response_error), 64'd0);
        end
        @(posedge clk); #1;
        arp_response_ready = 1'b1;
        wait_resp(base + 1, 50);
        @(posedge clk); #1;

        // Reset while waiting on the cache; the late answer must be swallowed.
        cache_auto = 0;
        exp_target = 32'hC0A8010A;
        do_request(32'hC0A8010A, 1'b0, 1'b0, 48'h0);
        w = 0;
        @(negedge clk);
        while (!cache_query_response_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("reached cache wait", 64'(cache_query_response_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_zero("mid reset");
        cache_query_response_valid = 1'b1;
        cache_query_response_error = 1'b0;
        cache_query_response_mac   = 48'h123456789ABC;
        repeat (2) @(posedge clk);
        #1;
        release_reset();
        @(posedge clk); #1;
        cache_query_response_valid = 1'b0;
        saw_resp = 0;
        repeat (6) begin
            @(negedge clk);
            if (arp_response_valid) saw_resp = 1;
        end
        check("no response from late cache answer", 64'(saw_resp), 64'd0);
        check("idle after flush", 64'(arp_request_ready), 64'd1);
        @(posedge clk); #1;

        cache_auto  = 1;
        exp_target  = 32'hC0A80137;
        miss_base   = cache_resp_cnt;
        miss_budget = 0;
        base = n_resp;
        do_request(32'hC0A80137, 1'b1, 1'b0, 48'h020000000037);
        wait_resp(base + 1, 200);

        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
